// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave response mux with built-in default slave for unmapped NONSEQ/SEQ accesses.
// Zero added latency: response path is combinational from the data-phase select; waits follow the selected slave.
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  ERR_CNT,
  output logic [31:0] ERR_ADDR
);

  typedef enum logic [2:0] {
    DSEL_NONE, DSEL_P0, DSEL_P1, DSEL_P2, DSEL_P3, DSEL_P4, DSEL_DEF
  } dsel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_e;

  localparam logic [4:0] PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

  dsel_e      dsel;
  dsel_e      dsel_load;
  state_e     state;
  state_e     state_nxt;
  logic [4:0] sel_vec;
  logic       accept;
  logic       load_def;
  logic       unused_htrans;

  // HTRANS[0] only distinguishes SEQ from NONSEQ / BUSY from IDLE, which this block treats alike.
  assign unused_htrans = HTRANS[0];

  assign sel_vec  = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign accept   = HREADY & HTRANS[1];
  assign load_def = (dsel_load == DSEL_DEF);

  always_comb begin
    dsel_load = DSEL_NONE;
    if (sel_vec[0])      dsel_load = DSEL_P0;
    else if (sel_vec[1]) dsel_load = DSEL_P1;
    else if (sel_vec[2]) dsel_load = DSEL_P2;
    else if (sel_vec[3]) dsel_load = DSEL_P3;
    else if (sel_vec[4]) dsel_load = DSEL_P4;
    else if (accept)     dsel_load = DSEL_DEF;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel <= DSEL_NONE;
    end else if (HREADY) begin
      dsel <= dsel_load;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // load_def already implies HREADY=1, so the default slave only starts on an accepted transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_def) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = load_def ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ERR_CNT <= 8'h00;
    end else if ((state == ST_ERR1) && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'h01;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ERR_ADDR <= 32'h0;
    end else if (load_def) begin
      ERR_ADDR <= HADDR;
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    case (dsel)
      DSEL_P0: begin HREADY = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
      DSEL_P1: begin HREADY = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
      DSEL_P2: begin HREADY = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
      DSEL_P3: begin HREADY = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
      DSEL_P4: begin HREADY = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
      DSEL_DEF: begin
        HREADY = (state == ST_ERR2);
        HRESP  = 1'b1;
      end
      default: begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux: a full build and a Port3-disabled build share one stimulus,
// each checked every cycle against a transaction-level model plus literal expectations.
module tb_ahblite_slave_mux;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [4:0]  hsel;
  logic [4:0]  hrdy;
  logic [4:0]  hrsp;
  logic [31:0] hrd [5];

  logic [1:0]  b_ready;
  logic [1:0]  b_resp;
  logic [31:0] b_rdata [2];
  logic [7:0]  b_cnt [2];
  logic [31:0] b_eaddr [2];

  int n_chk = 0;
  int n_err = 0;

  ahblite_slave_mux u_full (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(htrans), .HADDR(haddr),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hrdy[0]), .P1_HREADYOUT(hrdy[1]), .P2_HREADYOUT(hrdy[2]),
    .P3_HREADYOUT(hrdy[3]), .P4_HREADYOUT(hrdy[4]),
    .P0_HRESP(hrsp[0]), .P1_HRESP(hrsp[1]), .P2_HRESP(hrsp[2]), .P3_HRESP(hrsp[3]), .P4_HRESP(hrsp[4]),
    .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]), .P3_HRDATA(hrd[3]), .P4_HRDATA(hrd[4]),
    .HREADY(b_ready[0]), .HRESP(b_resp[0]), .HRDATA(b_rdata[0]),
    .ERR_CNT(b_cnt[0]), .ERR_ADDR(b_eaddr[0])
  );

  ahblite_slave_mux #(.Port3_en(1'b0)) u_p3off (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(htrans), .HADDR(haddr),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hrdy[0]), .P1_HREADYOUT(hrdy[1]), .P2_HREADYOUT(hrdy[2]),
    .P3_HREADYOUT(hrdy[3]), .P4_HREADYOUT(hrdy[4]),
    .P0_HRESP(hrsp[0]), .P1_HRESP(hrsp[1]), .P2_HRESP(hrsp[2]), .P3_HRESP(hrsp[3]), .P4_HRESP(hrsp[4]),
    .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]), .P3_HRDATA(hrd[3]), .P4_HRDATA(hrd[4]),
    .HREADY(b_ready[1]), .HRESP(b_resp[1]), .HRDATA(b_rdata[1]),
    .ERR_CNT(b_cnt[1]), .ERR_ADDR(b_eaddr[1])
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Model: sel 0..4 = port, 5 = default slave, 7 = nothing; left = error cycles still to present.
  typedef struct packed {
    logic [2:0]  sel;
    logic [1:0]  left;
    logic [7:0]  cnt;
    logic [31:0] addr;
  } mstate_t;

  localparam mstate_t M_RESET = '{sel: 3'd7, left: 2'd0, cnt: 8'd0, addr: 32'h0};

  mstate_t ms [2];

  function automatic logic [4:0] en_of(int k);
    return (k == 0) ? 5'h1F : 5'h17;
  endfunction

  function automatic logic exp_ready(mstate_t s);
    if (s.sel <= 3'd4) return hrdy[s.sel];
    if (s.sel == 3'd5) return (s.left == 2'd1);
    return 1'b1;
  endfunction

  function automatic logic exp_resp(mstate_t s);
    if (s.sel <= 3'd4) return hrsp[s.sel];
    return (s.sel == 3'd5);
  endfunction

  function automatic logic [31:0] exp_rdata(mstate_t s);
    if (s.sel <= 3'd4) return hrd[s.sel];
    return 32'h0;
  endfunction

  function automatic mstate_t next_state(mstate_t s, logic [4:0] en);
    mstate_t n;
    logic    found;
    n = s;
    found = 1'b0;
    if (s.sel == 3'd5 && s.left == 2'd2) begin
      n.left = 2'd1;
      n.cnt  = (s.cnt == 8'hFF) ? 8'hFF : s.cnt + 8'd1;
    end
    if (exp_ready(s)) begin
      n.sel  = 3'd7;
      n.left = 2'd0;
      for (int i = 0; i < 5; i++) begin
        if (!found && hsel[i] && en[i]) begin
          n.sel = 3'(i);
          found = 1'b1;
        end
      end
      if (!found && htrans[1]) begin
        n.sel  = 3'd5;
        n.left = 2'd2;
        n.addr = haddr;
      end
    end
    return n;
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    for (int k = 0; k < 2; k++) begin
      if (HRESET) ms[k] <= M_RESET;
      else        ms[k] <= next_state(ms[k], en_of(k));
    end
  end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s[dut%0d] actual=%h required=%h t=%0t", nm, k, act, req, $time);
    end
  endtask

  always @(negedge HCLK) begin
    for (int k = 0; k < 2; k++) begin
      chk("m_ready", k, 32'(b_ready[k]), 32'(exp_ready(ms[k])));
      chk("m_resp",  k, 32'(b_resp[k]),  32'(exp_resp(ms[k])));
      chk("m_rdata", k, b_rdata[k],      exp_rdata(ms[k]));
      chk("m_cnt",   k, 32'(b_cnt[k]),   32'(ms[k].cnt));
      chk("m_eaddr", k, b_eaddr[k],      ms[k].addr);
    end
  end

  task automatic to_neg();
    @(negedge HCLK);
  endtask

  task automatic to_pos();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    htrans = 2'b00;
    hsel   = 5'b0;
  endtask

  task automatic chk_both(string nm, logic rdy, logic rsp);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_ready"}, k, 32'(b_ready[k]), 32'(rdy));
      chk({nm, "_resp"},  k, 32'(b_resp[k]),  32'(rsp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int  bub;
  logic seen;
  logic prev;

  initial begin
    HRESET = 1'b1;
    htrans = 2'b00;
    haddr  = 32'h0;
    hsel   = 5'b0;
    hrdy   = 5'h1F;
    hrsp   = 5'h0;
    for (int i = 0; i < 5; i++) hrd[i] = 32'h0;

    to_neg();
    chk_both("rst", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdata", k, b_rdata[k], 32'h0);
      chk("rst_cnt",   k, 32'(b_cnt[k]), 32'h0);
      chk("rst_eaddr", k, b_eaddr[k], 32'h0);
    end
    to_pos();
    HRESET = 1'b0;

    // P2 zero-wait read
    htrans = 2'b10; haddr = 32'h2000_0010; hsel = 5'b00100; hrd[2] = 32'h1234_5678;
    to_neg(); to_pos();
    idle_bus();
    to_neg();
    chk_both("p2rd", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk("p2rd_rdata", k, b_rdata[k], 32'h1234_5678);
    to_pos();

    // P4 with three wait states while P0 waits in the address phase
    htrans = 2'b10; haddr = 32'h4000_0000; hsel = 5'b10000; hrdy[4] = 1'b0; hrd[4] = 32'h4444_4444;
    to_neg(); to_pos();
    hsel = 5'b00001; haddr = 32'h0000_0100; hrd[0] = 32'hAAAA_0000;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk_both("p4wait", 1'b0, 1'b0);
      chk("p4wait_rdata", 0, b_rdata[0], 32'h4444_4444);
      to_pos();
    end
    hrdy[4] = 1'b1;
    to_neg();
    chk_both("p4done", 1'b1, 1'b0);
    to_pos();
    idle_bus();
    to_neg();
    for (int k = 0; k < 2; k++) chk("p0_after_p4", k, b_rdata[k], 32'hAAAA_0000);
    to_pos();

    // Unmapped NONSEQ: two-cycle ERROR
    htrans = 2'b10; haddr = 32'h5000_0000; hsel = 5'b0;
    to_neg(); to_pos();
    idle_bus(); haddr = 32'h0;
    to_neg();
    chk_both("err1", 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) chk("err1_eaddr", k, b_eaddr[k], 32'h5000_0000);
    to_pos();
    to_neg();
    chk_both("err2", 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) chk("err2_cnt", k, 32'(b_cnt[k]), 32'd1);
    to_pos();

    // IDLE then BUSY to unmapped address: OKAY, count and address untouched
    htrans = 2'b00; haddr = 32'h6000_0000;
    to_neg(); to_pos();
    htrans = 2'b01;
    to_neg();
    chk_both("idle_unmapped", 1'b1, 1'b0);
    to_pos();
    idle_bus();
    to_neg();
    chk_both("busy_unmapped", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("idle_cnt",   k, 32'(b_cnt[k]), 32'd1);
      chk("idle_eaddr", k, b_eaddr[k], 32'h5000_0000);
    end
    to_pos();

    // Long run of unmapped NONSEQ: saturating count, no bubble between errors
    htrans = 2'b10; hsel = 5'b0;
    bub = 0; seen = 1'b0; prev = 1'b0;
    for (int i = 0; i < 610; i++) begin
      haddr = 32'h7000_0000 + 32'(i);
      to_neg();
      if (!b_ready[0]) seen = 1'b1;
      else if (seen && prev) bub++;
      prev = b_ready[0];
      to_pos();
    end
    idle_bus();
    to_neg();
    for (int k = 0; k < 2; k++) chk("sat_cnt", k, 32'(b_cnt[k]), 32'h0000_00FF);
    chk("sat_model_cnt", 0, 32'(ms[0].cnt), 32'h0000_00FF);
    chk("err_bubbles", 0, 32'(bub), 32'd0);
    to_pos(); to_neg(); to_pos(); to_neg(); to_pos();

    // P3 access: served by the full build, ERROR from the Port3-disabled build
    htrans = 2'b10; haddr = 32'h3000_0000; hsel = 5'b01000; hrd[3] = 32'h3333_3333;
    to_neg(); to_pos();
    idle_bus();
    to_neg();
    chk("p3_full_rdata", 0, b_rdata[0], 32'h3333_3333);
    chk("p3_full_ready", 0, 32'(b_ready[0]), 32'd1);
    chk("p3_off_ready",  1, 32'(b_ready[1]), 32'd0);
    chk("p3_off_resp",   1, 32'(b_resp[1]),  32'd1);
    chk("p3_off_eaddr",  1, b_eaddr[1], 32'h3000_0000);
    #2;
    HRESET = 1'b1;
    #1;
    chk("rst_err1_ready", 1, 32'(b_ready[1]), 32'd1);
    chk("rst_err1_resp",  1, 32'(b_resp[1]),  32'd0);
    chk("rst_err1_cnt",   1, 32'(b_cnt[1]),   32'd0);
    chk("rst_err1_eaddr", 1, b_eaddr[1], 32'h0);
    chk("rst_err1_cnt",   0, 32'(b_cnt[0]),   32'd0);
    to_pos();
    HRESET = 1'b0;

    // First access after reset
    htrans = 2'b10; haddr = 32'h1000_0000; hsel = 5'b00010; hrd[1] = 32'h1111_1111;
    to_neg(); to_pos();
    idle_bus();
    to_neg();
    chk_both("post_rst", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk("post_rst_rdata", k, b_rdata[k], 32'h1111_1111);
    to_pos();
    to_neg();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Port0_en, 1, port 0 response path enabled.
- Port1_en, 1, port 1 response path enabled.
- Port2_en, 1, port 2 response path enabled.
- Port3_en, 1, port 3 response path enabled.
- Port4_en, 1, port 4 response path enabled.
REQ-002 Ports (name, direction, width, meaning), one per line:
- HCLK in 1: single clock, rising edge.
- HRESET in 1: asynchronous, active-high reset.
- HTRANS in 2: master transfer type.
- HADDR in 32: master address.
- P0_HSEL..P4_HSEL in 1 each: address-phase selects from the address decoder.
- P0_HREADYOUT..P4_HREADYOUT in 1 each: slave ready.
- P0_HRESP..P4_HRESP in 1 each: slave response (1 = ERROR).
- P0_HRDATA..P4_HRDATA in 32 each: slave read data.
- HREADY out 1: bus ready, returned to master and all slaves.
- HRESP out 1: bus response.
- HRDATA out 32: bus read data.
- ERR_CNT out 8: count of ERROR responses issued by the internal default slave.
- ERR_ADDR out 32: HADDR of the most recent unmapped access.

Function
REQ-003 Address-phase accept: accept = HREADY (own output) AND HTRANS[1].
REQ-004 Data-phase select register (DSEL, one of NONE, P0..P4, DEF) loads on every HCLK edge where HREADY=1; it holds while HREADY=0.
REQ-005 On load, DSEL takes the lowest-index port n where Pn_HSEL=1 and Portn_en=1.
REQ-006 On load with no qualifying port: DSEL=DEF if accept=1, else NONE.
REQ-007 Port n with Portn_en=0 is treated as never selected, so its HSEL falls through to REQ-006.
REQ-008 Response mux, DSEL=Pn: HREADY=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA.
REQ-009 Response mux, DSEL=NONE: HREADY=1, HRESP=0, HRDATA=0.
REQ-010 Default slave FSM states IDLE, ERR1, ERR2.
- IDLE->ERR1 on the edge that loads DSEL=DEF.
- ERR1->ERR2 unconditionally on the next edge.
- ERR2->ERR1 if that edge loads DSEL=DEF again, else ERR2->IDLE.
REQ-011 Default slave outputs while DSEL=DEF: HRDATA=0; ERR1: HREADY=0, HRESP=1; ERR2: HREADY=1, HRESP=1. This is the two-cycle AHB-Lite ERROR response.
REQ-012 IDLE/BUSY transfers (HTRANS[1]=0) never enter DEF and get zero-wait OKAY.
REQ-013 ERR_CNT increments by 1 on each ERR1->ERR2 transition and saturates at 8'hFF with no wrap.
REQ-014 ERR_ADDR loads HADDR on the edge that loads DSEL=DEF, and holds otherwise.
REQ-015 Outputs are combinational from DSEL, FSM state and slave inputs; no additional latency beyond the AHB address/data pipeline.
REQ-016 Back-to-back transfers: when DSEL=Pn and Pn_HREADYOUT=1, the same edge loads the next address-phase select (pipelined, no bubble).

Reset
REQ-017 HRESET=1 asynchronously forces DSEL=NONE, FSM=IDLE, ERR_CNT=0, ERR_ADDR=0. Outputs are then HREADY=1, HRESP=0, HRDATA=0.
REQ-018 Reset asserted mid-wait-state or mid-ERROR aborts the transfer immediately. The first post-reset edge with accept behaves per REQ-004..006.

Verification
REQ-019 The bench shall cover these directed scenarios:
- NONSEQ read, P2_HSEL=1, P2_HRDATA=32'h12345678, P2_HREADYOUT=1 -> next cycle HRDATA=32'h12345678, HREADY=1, HRESP=0.
- P4 data phase with P4_HREADYOUT low for 3 cycles -> HREADY=0 for 3 cycles; DSEL holds while a new P0_HSEL is presented; P0 is selected only after HREADY=1.
- NONSEQ to HADDR=32'h50000000, no HSEL -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1); ERR_ADDR=32'h50000000; ERR_CNT=1.
- IDLE transfer to unmapped address -> HREADY=1, HRESP=0; ERR_CNT unchanged.
- 300 consecutive unmapped NONSEQ -> ERR_CNT=8'hFF; back-to-back ERR2->ERR1 with no IDLE cycle between.
- Port3_en=0 build, P3_HSEL=1 with NONSEQ -> ERROR response; HRESET pulse during ERR1 -> HREADY=1, HRESP=0, ERR_CNT=0 immediately.
